tinker_exec_unit: RTL and testbench
===================================

Name: tinker_exec_unit

Overview:
- Clocked, parametrised successor to the combinational Tinker datapath.
- Accepts one 32-bit Tinker instruction per valid/ready handshake and executes it against an internal 32-entry register file of XLEN-bit registers.
- Presents the written-back result on a valid/ready response channel.
- Adds what the combinational datapath lacks: registered write-back, multi-cycle iterative divide, backpressure, illegal-opcode and divide-by-zero flags, and a debug read port.

Parameters:
- XLEN, 64, register and datapath width; legal values 32 or 64.
- SHAMT_W, $clog2(XLEN), number of low operand bits used as the shift amount.

Ports:
- clk  in  1  clock.
- reset  in  1  synchronous, active-high reset.
- instr_valid  in  1  instruction offered.
- instr_ready  out  1  unit can accept an instruction.
- instr  in  32  opcode[31:27], rd[26:22], rs[21:17], rt[16:12], L[11:0].
- res_valid  out  1  response available.
- res_ready  in  1  consumer accepts the response.
- res_data  out  XLEN  value written to rd (zero when illegal).
- res_rd  out  5  destination register index.
- res_illegal  out  1  opcode not supported; no write performed.
- res_div0  out  1  DIV executed with a zero divisor.
- dbg_addr  in  5  debug read index.
- dbg_data  out  XLEN  combinational read of reg[dbg_addr].

Behaviour:
- Reset: all 32 registers = 0; state = IDLE; instr_ready = 1; res_valid = 0; res_data = 0; res_rd = 0; res_illegal = 0; res_div0 = 0.
- A reset asserted mid-operation aborts any divide or pending response. The unit returns to IDLE on the next edge; any pending write is discarded.
- States:
  - IDLE: instr_ready = 1. On instr_valid, latch the instruction and read operands.
    - DIV goes to DIV state.
    - All other opcodes compute the result, write back and register the response on the same edge, then go to RESP.
  - DIV: radix-2 restoring unsigned divide, one quotient bit per cycle, XLEN cycles. On the last iteration, write back and register the response, then go to RESP.
  - RESP: res_valid = 1. Outputs stay stable until res_ready. On res_valid && res_ready, go to IDLE.
- instr_ready is 0 outside IDLE. No instruction is accepted in the same cycle a response retires; there is no overlap.
- Latency from the accept edge to res_valid high:
  - 1 cycle for non-DIV opcodes.
  - XLEN+1 cycles for DIV.
- Operand rules:
  - imm = L sign-extended to XLEN.
  - Register-register ops: rd = rs OP rt.
  - Immediate ops: rd = rd OP imm.
- Operations, by opcode:
  - AND 00000, OR 00001, XOR 00010.
  - NOT 00011: rd = ~rs.
  - SHFTR 00100 / SHFTRI 00101: logical right shift by operand2[SHAMT_W-1:0].
  - SHFTL 00110 / SHFTLI 00111: left shift by operand2[SHAMT_W-1:0].
  - MOV 10001: rd = rs.
  - MOVI 10010: rd = imm.
  - ADD 11000 / ADDI 11001, SUB 11010 / SUBI 11011: modulo 2^XLEN, carry discarded.
  - MUL 11100: low XLEN bits of the product, single cycle.
  - DIV 11101: unsigned quotient.
- Divide by zero: still takes XLEN cycles; result = all ones; res_div0 = 1; write still performed.
- Any other opcode, including FP 10100–10111, is illegal: res_illegal = 1, res_data = 0, register file unchanged, 1-cycle latency.
- Register file:
  - Operands are read from the pre-write state.
  - rd == rs == rt is legal; the result is computed from old values.
  - r0 is an ordinary register.
- dbg_data reflects the write one cycle after the write edge.

Test Plan:
- Reset, then MOVI r1, L=0xFFF -> res_valid on cycle 1; res_data = 0xFFFF_FFFF_FFFF_FFFF; res_rd = 1; dbg_addr = 1 reads the same value.
- r2 = 100, r3 = 7; DIV r4, r2, r3 -> res_valid exactly 65 cycles after accept; res_data = 14; instr_ready low throughout.
- DIV r5, r2, r0 with r0 = 0 -> res_data = all ones; res_div0 = 1; r5 updated.
- res_ready held low for 5 cycles after ADDI r2, L=-1 -> res_valid, res_data = 99 and res_rd stable; instr_valid ignored; one write only.
- Opcode 10100 (ADDF) -> res_illegal = 1, res_data = 0; all registers unchanged. Then SHFTLI r3, L=70 with XLEN=64 -> shift by 6; 7 << 6 = 448.
- Reset asserted at iteration 30 of a DIV -> next cycle in IDLE, instr_ready = 1, res_valid = 0, all registers read 0.

Source files
------------

// File: rtl/tinker_exec_unit.sv
// Tinker execution unit: accepts one instruction per handshake, runs it
// against a 32-entry register file and returns the written-back value on a
// response channel. DIV runs as an iterative restoring divider.
//
// Handshake rules: an instruction transfers on a rising edge where
// instr_valid && instr_ready; a response retires on a rising edge where
// res_valid && res_ready. The producer holds instr stable while instr_valid is
// high. The unit holds every res_* output stable while res_valid is high. The
// two channels never overlap: instr_ready is high only in IDLE, and
// res_valid is high only in RESP.
module tinker_exec_unit #(
    parameter int XLEN    = 64,
    parameter int SHAMT_W = $clog2(XLEN)
) (
    input  logic            clk,
    input  logic            reset,
    input  logic            instr_valid,
    output logic            instr_ready,
    input  logic [31:0]     instr,
    output logic            res_valid,
    input  logic            res_ready,
    output logic [XLEN-1:0] res_data,
    output logic [4:0]      res_rd,
    output logic            res_illegal,
    output logic            res_div0,
    input  logic [4:0]      dbg_addr,
    output logic [XLEN-1:0] dbg_data
);

    // Opcode map
    localparam logic [4:0] OP_AND    = 5'b00000;
    localparam logic [4:0] OP_OR     = 5'b00001;
    localparam logic [4:0] OP_XOR    = 5'b00010;
    localparam logic [4:0] OP_NOT    = 5'b00011;
    localparam logic [4:0] OP_SHFTR  = 5'b00100;
    localparam logic [4:0] OP_SHFTRI = 5'b00101;
    localparam logic [4:0] OP_SHFTL  = 5'b00110;
    localparam logic [4:0] OP_SHFTLI = 5'b00111;
    localparam logic [4:0] OP_MOV    = 5'b10001;
    localparam logic [4:0] OP_MOVI   = 5'b10010;
    localparam logic [4:0] OP_ADD    = 5'b11000;
    localparam logic [4:0] OP_ADDI   = 5'b11001;
    localparam logic [4:0] OP_SUB    = 5'b11010;
    localparam logic [4:0] OP_SUBI   = 5'b11011;
    localparam logic [4:0] OP_MUL    = 5'b11100;
    localparam logic [4:0] OP_DIV    = 5'b11101;

    typedef enum logic [1:0] {
        ST_IDLE = 2'd0,
        ST_DIV  = 2'd1,
        ST_RESP = 2'd2
    } state_t;

    // Architectural and control state
    state_t              state_q;
    logic [XLEN-1:0]     regs_q [32];
    logic                instr_ready_q;
    logic                res_valid_q;
    logic [XLEN-1:0]     res_data_q;
    logic [4:0]          res_rd_q;
    logic                res_illegal_q;
    logic                res_div0_q;

    // Divider state: quo_q starts as the dividend and is shifted out MSB
    // first while quotient bits are shifted in at the bottom.
    logic [XLEN-1:0]     quo_q;
    logic [XLEN-1:0]     rem_q;
    logic [XLEN-1:0]     divisor_q;
    logic [SHAMT_W-1:0]  cnt_q;
    logic [4:0]          div_rd_q;
    logic                div0_q;

    // Instruction fields
    logic [4:0]          opcode;
    logic [4:0]          rd_idx;
    logic [4:0]          rs_idx;
    logic [4:0]          rt_idx;
    logic [XLEN-1:0]     imm;
    logic [XLEN-1:0]     rd_val;
    logic [XLEN-1:0]     rs_val;
    logic [XLEN-1:0]     rt_val;

    assign opcode = instr[31:27];
    assign rd_idx = instr[26:22];
    assign rs_idx = instr[21:17];
    assign rt_idx = instr[16:12];
    assign imm    = {{(XLEN-12){instr[11]}}, instr[11:0]};

    // Operands always come from the pre-write register state.
    assign rd_val = regs_q[rd_idx];
    assign rs_val = regs_q[rs_idx];
    assign rt_val = regs_q[rt_idx];

    // Single-cycle ALU result and legality decode
    logic [XLEN-1:0]     alu_res;
    logic                alu_illegal;

    // Combinational single-cycle operations; DIV is handled by the divider.
    always_comb begin
        alu_res     = '0;
        alu_illegal = 1'b0;
        case (opcode)
            OP_AND:    alu_res = rs_val & rt_val;
            OP_OR:     alu_res = rs_val | rt_val;
            OP_XOR:    alu_res = rs_val ^ rt_val;
            OP_NOT:    alu_res = ~rs_val;
            OP_SHFTR:  alu_res = rs_val >> rt_val[SHAMT_W-1:0];
            OP_SHFTRI: alu_res = rd_val >> imm[SHAMT_W-1:0];
            OP_SHFTL:  alu_res = rs_val << rt_val[SHAMT_W-1:0];
            OP_SHFTLI: alu_res = rd_val << imm[SHAMT_W-1:0];
            OP_MOV:    alu_res = rs_val;
            OP_MOVI:   alu_res = imm;
            OP_ADD:    alu_res = rs_val + rt_val;
            OP_ADDI:   alu_res = rd_val + imm;
            OP_SUB:    alu_res = rs_val - rt_val;
            OP_SUBI:   alu_res = rd_val - imm;
            OP_MUL:    alu_res = rs_val * rt_val;
            OP_DIV:    alu_res = '0;
            default:   alu_illegal = 1'b1;
        endcase
    end

    // One restoring-divide step
    logic [XLEN:0]       rem_shift;
    logic [XLEN:0]       trial;
    logic [XLEN-1:0]     rem_d;
    logic [XLEN-1:0]     quo_d;

    // Shift in the next dividend bit, subtract the divisor, keep the
    // difference if it did not go negative. A zero divisor never goes
    // negative, so the quotient naturally saturates to all ones.
    always_comb begin
        rem_shift = {rem_q, quo_q[XLEN-1]};
        trial     = rem_shift - {1'b0, divisor_q};
        if (!trial[XLEN]) begin
            rem_d = trial[XLEN-1:0];
            quo_d = {quo_q[XLEN-2:0], 1'b1};
        end else begin
            rem_d = rem_shift[XLEN-1:0];
            quo_d = {quo_q[XLEN-2:0], 1'b0};
        end
    end

    // Main control FSM: accept, execute or iterate, write back, respond.
    always_ff @(posedge clk) begin
        if (reset) begin
            for (int i = 0; i < 32; i++) begin
                regs_q[i] <= '0;
            end
            state_q       <= ST_IDLE;
            instr_ready_q <= 1'b1;
            res_valid_q   <= 1'b0;
            res_data_q    <= '0;
            res_rd_q      <= '0;
            res_illegal_q <= 1'b0;
            res_div0_q    <= 1'b0;
            quo_q         <= '0;
            rem_q         <= '0;
            divisor_q     <= '0;
            cnt_q         <= '0;
            div_rd_q      <= '0;
            div0_q        <= 1'b0;
        end else begin
            case (state_q)
                ST_IDLE: begin
                    if (instr_valid) begin
                        instr_ready_q <= 1'b0;
                        if (opcode == OP_DIV) begin
                            quo_q     <= rs_val;
                            rem_q     <= '0;
                            divisor_q <= rt_val;
                            div0_q    <= (rt_val == '0);
                            div_rd_q  <= rd_idx;
                            cnt_q     <= SHAMT_W'(XLEN - 1);
                            state_q   <= ST_DIV;
                        end else begin
                            if (!alu_illegal) begin
                                regs_q[rd_idx] <= alu_res;
                            end
                            res_data_q    <= alu_illegal ? '0 : alu_res;
                            res_rd_q      <= rd_idx;
                            res_illegal_q <= alu_illegal;
                            res_div0_q    <= 1'b0;
                            res_valid_q   <= 1'b1;
                            state_q       <= ST_RESP;
                        end
                    end
                end
                ST_DIV: begin
                    quo_q <= quo_d;
                    rem_q <= rem_d;
                    cnt_q <= cnt_q - SHAMT_W'(1);
                    if (cnt_q == '0) begin
                        regs_q[div_rd_q] <= quo_d;
                        res_data_q       <= quo_d;
                        res_rd_q         <= div_rd_q;
                        res_illegal_q    <= 1'b0;
                        res_div0_q       <= div0_q;
                        res_valid_q      <= 1'b1;
                        state_q          <= ST_RESP;
                    end
                end
                ST_RESP: begin
                    if (res_ready) begin
                        res_valid_q   <= 1'b0;
                        instr_ready_q <= 1'b1;
                        state_q       <= ST_IDLE;
                    end
                end
                default: begin
                    res_valid_q   <= 1'b0;
                    instr_ready_q <= 1'b1;
                    state_q       <= ST_IDLE;
                end
            endcase
        end
    end

    assign instr_ready = instr_ready_q;
    assign res_valid   = res_valid_q;
    assign res_data    = res_data_q;
    assign res_rd      = res_rd_q;
    assign res_illegal = res_illegal_q;
    assign res_div0    = res_div0_q;
    assign dbg_data    = regs_q[dbg_addr];

endmodule

// File: tb/tb_tinker_exec_unit.sv
// Directed bench for tinker_exec_unit (XLEN = 64): a table of single-cycle
// instructions with hand-computed results, then hand-written sequences for
// divide, divide-by-zero, backpressure, illegal opcodes and mid-divide reset.
module tb_tinker_exec_unit;

    localparam int XLEN = 64;

    logic            clk = 1'b0;
    logic            reset;
    logic            instr_valid;
    logic            instr_ready;
    logic [31:0]     instr;
    logic            res_valid;
    logic            res_ready;
    logic [XLEN-1:0] res_data;
    logic [4:0]      res_rd;
    logic            res_illegal;
    logic            res_div0;
    logic [4:0]      dbg_addr;
    logic [XLEN-1:0] dbg_data;

    int tests = 0;
    int fails = 0;

    logic [XLEN-1:0] exp_regs [32];

    tinker_exec_unit #(.XLEN(XLEN)) dut (
        .clk         (clk),
        .reset       (reset),
        .instr_valid (instr_valid),
        .instr_ready (instr_ready),
        .instr       (instr),
        .res_valid   (res_valid),
        .res_ready   (res_ready),
        .res_data    (res_data),
        .res_rd      (res_rd),
        .res_illegal (res_illegal),
        .res_div0    (res_div0),
        .dbg_addr    (dbg_addr),
        .dbg_data    (dbg_data)
    );

    // Clock
    always #5 clk = ~clk;

    typedef struct {
        logic [4:0]      op;
        logic [4:0]      rd;
        logic [4:0]      rs;
        logic [4:0]      rt;
        logic [11:0]     l;
        logic [XLEN-1:0] exp;
    } vec_t;

    vec_t vecs [20];

    task automatic chk(input string name, input logic [XLEN-1:0] act, input logic [XLEN-1:0] exp);
        tests++;
        if (act !== exp) begin
            fails++;
            $display("FAIL %s actual=%h required=%h", name, act, exp);
        end
    endtask

    function automatic logic [31:0] enc(input logic [4:0] op, input logic [4:0] rd,
                                        input logic [4:0] rs, input logic [4:0] rt,
                                        input logic [11:0] l);
        return {op, rd, rs, rt, l};
    endfunction

    // Offer one instruction for one edge; the unit is expected to be in IDLE.
    task automatic issue(input logic [31:0] ins);
        @(negedge clk);
        instr       = ins;
        instr_valid = 1'b1;
        @(posedge clk);
        #1;
        instr_valid = 1'b0;
    endtask

    // Count edges from the accept edge until res_valid; note any instr_ready.
    task automatic wait_resp(input int max_cyc, output int lat, output logic rdy_seen);
        lat      = 1;
        rdy_seen = 1'b0;
        while (!res_valid && lat < max_cyc) begin
            rdy_seen = rdy_seen | instr_ready;
            @(posedge clk);
            #1;
            lat++;
        end
        rdy_seen = rdy_seen | instr_ready;
    endtask

    task automatic retire();
        @(posedge clk);
        #1;
    endtask

    task automatic read_reg(input logic [4:0] a, output logic [XLEN-1:0] v);
        dbg_addr = a;
        #1;
        v = dbg_data;
    endtask

    task automatic do_reset();
        @(negedge clk);
        reset = 1'b1;
        @(posedge clk);
        #1;
        reset = 1'b0;
        for (int i = 0; i < 32; i++) exp_regs[i] = '0;
    endtask

    initial begin
        int              lat;
        logic            rdy_seen;
        logic [XLEN-1:0] v;
        logic            stable;

        // Hand-computed vector table, applied in order from a reset state.
        vecs[0]  = '{5'b10010, 5'd1,  5'd0,  5'd0,  12'hFFF, 64'hFFFF_FFFF_FFFF_FFFF}; // MOVI r1,-1
        vecs[1]  = '{5'b10010, 5'd2,  5'd0,  5'd0,  12'h064, 64'd100};                 // MOVI r2,100
        vecs[2]  = '{5'b10010, 5'd3,  5'd0,  5'd0,  12'h007, 64'd7};                   // MOVI r3,7
        vecs[3]  = '{5'b11000, 5'd6,  5'd2,  5'd3,  12'h000, 64'd107};                 // ADD
        vecs[4]  = '{5'b11010, 5'd7,  5'd3,  5'd2,  12'h000, 64'hFFFF_FFFF_FFFF_FFA3}; // SUB 7-100
        vecs[5]  = '{5'b11100, 5'd8,  5'd2,  5'd3,  12'h000, 64'd700};                 // MUL
        vecs[6]  = '{5'b00000, 5'd9,  5'd1,  5'd2,  12'h000, 64'd100};                 // AND
        vecs[7]  = '{5'b11000, 5'd9,  5'd9,  5'd9,  12'h000, 64'd200};                 // ADD rd=rs=rt
        vecs[8]  = '{5'b00001, 5'd10, 5'd2,  5'd3,  12'h000, 64'd103};                 // OR
        vecs[9]  = '{5'b00010, 5'd11, 5'd2,  5'd3,  12'h000, 64'd99};                  // XOR
        vecs[10] = '{5'b00011, 5'd12, 5'd2,  5'd0,  12'h000, 64'hFFFF_FFFF_FFFF_FF9B}; // NOT
        vecs[11] = '{5'b00100, 5'd13, 5'd1,  5'd3,  12'h000, 64'h01FF_FFFF_FFFF_FFFF}; // SHFTR by 7
        vecs[12] = '{5'b00110, 5'd14, 5'd3,  5'd3,  12'h000, 64'd896};                 // SHFTL 7<<7
        vecs[13] = '{5'b10001, 5'd15, 5'd8,  5'd0,  12'h000, 64'd700};                 // MOV
        vecs[14] = '{5'b11001, 5'd15, 5'd0,  5'd0,  12'h800, 64'hFFFF_FFFF_FFFF_FABC}; // ADDI -2048
        vecs[15] = '{5'b11011, 5'd6,  5'd0,  5'd0,  12'h007, 64'd100};                 // SUBI 7
        vecs[16] = '{5'b00101, 5'd1,  5'd0,  5'd0,  12'h03C, 64'h0000_0000_0000_000F}; // SHFTRI 60
        vecs[17] = '{5'b10010, 5'd0,  5'd0,  5'd0,  12'h005, 64'd5};                   // MOVI r0,5
        vecs[18] = '{5'b11010, 5'd0,  5'd0,  5'd0,  12'h000, 64'd0};                   // SUB r0-r0
        vecs[19] = '{5'b10010, 5'd16, 5'd0,  5'd0,  12'h7FF, 64'd2047};                // MOVI max pos

        // Reset block
        reset       = 1'b1;
        instr_valid = 1'b0;
        instr       = '0;
        res_ready   = 1'b1;
        dbg_addr    = '0;
        repeat (3) @(posedge clk);
        #1;
        reset = 1'b0;
        for (int i = 0; i < 32; i++) exp_regs[i] = '0;

        chk("rst_instr_ready", 64'(instr_ready), 64'd1);
        chk("rst_res_valid",   64'(res_valid),   64'd0);
        chk("rst_res_data",    res_data,         64'd0);
        chk("rst_res_rd",      64'(res_rd),      64'd0);
        chk("rst_res_illegal", 64'(res_illegal), 64'd0);
        chk("rst_res_div0",    64'(res_div0),    64'd0);
        for (int i = 0; i < 32; i++) begin
            read_reg(5'(i), v);
            chk("rst_reg", v, 64'd0);
        end

        // Table-driven single-cycle operations
        for (int i = 0; i < 20; i++) begin
            issue(enc(vecs[i].op, vecs[i].rd, vecs[i].rs, vecs[i].rt, vecs[i].l));
            wait_resp(10, lat, rdy_seen);
            chk("vec_latency", 64'(lat), 64'd1);
            chk("vec_data",    res_data, vecs[i].exp);
            chk("vec_rd",      64'(res_rd), 64'(vecs[i].rd));
            chk("vec_illegal", 64'(res_illegal), 64'd0);
            read_reg(vecs[i].rd, v);
            chk("vec_dbg",     v, vecs[i].exp);
            exp_regs[vecs[i].rd] = vecs[i].exp;
            retire();
            chk("vec_ready_after", 64'(instr_ready), 64'd1);
        end

        // DIV r4 = r2 / r3 = 100 / 7
        issue(enc(5'b11101, 5'd4, 5'd2, 5'd3, 12'h000));
        wait_resp(100, lat, rdy_seen);
        chk("div_latency",  64'(lat), 64'd65);
        chk("div_ready_lo", 64'(rdy_seen), 64'd0);
        chk("div_data",     res_data, 64'd14);
        chk("div_rd",       64'(res_rd), 64'd4);
        chk("div_div0",     64'(res_div0), 64'd0);
        read_reg(5'd4, v);
        chk("div_dbg", v, 64'd14);
        exp_regs[4] = 64'd14;
        retire();

        // DIV r5 = r2 / r0 with r0 = 0
        issue(enc(5'b11101, 5'd5, 5'd2, 5'd0, 12'h000));
        wait_resp(100, lat, rdy_seen);
        chk("div0_latency", 64'(lat), 64'd65);
        chk("div0_data",    res_data, 64'hFFFF_FFFF_FFFF_FFFF);
        chk("div0_flag",    64'(res_div0), 64'd1);
        chk("div0_rd",      64'(res_rd), 64'd5);
        read_reg(5'd5, v);
        chk("div0_dbg", v, 64'hFFFF_FFFF_FFFF_FFFF);
        exp_regs[5] = 64'hFFFF_FFFF_FFFF_FFFF;
        retire();
        chk("div0_flag_next", 64'(res_valid), 64'd0);

        // Backpressure: ADDI r2,-1 held for 5 cycles with a competing offer
        res_ready = 1'b0;
        issue(enc(5'b11001, 5'd2, 5'd0, 5'd0, 12'hFFF));
        wait_resp(10, lat, rdy_seen);
        chk("bp_latency", 64'(lat), 64'd1);
        stable = 1'b1;
        for (int c = 0; c < 5; c++) begin
            @(negedge clk);
            instr       = enc(5'b10010, 5'd20, 5'd0, 5'd0, 12'h001);
            instr_valid = 1'b1;
            @(posedge clk);
            #1;
            if (!res_valid || res_data !== 64'd99 || res_rd !== 5'd2 || instr_ready)
                stable = 1'b0;
        end
        chk("bp_stable", 64'(stable), 64'd1);
        instr_valid = 1'b0;
        res_ready   = 1'b1;
        retire();
        chk("bp_retired_valid", 64'(res_valid), 64'd0);
        chk("bp_retired_ready", 64'(instr_ready), 64'd1);
        read_reg(5'd2, v);
        chk("bp_r2_once", v, 64'd99);
        read_reg(5'd20, v);
        chk("bp_r20_untouched", v, 64'd0);
        exp_regs[2] = 64'd99;

        // Illegal opcode 10100 (ADDF)
        issue(enc(5'b10100, 5'd3, 5'd2, 5'd2, 12'h123));
        wait_resp(10, lat, rdy_seen);
        chk("ill_latency", 64'(lat), 64'd1);
        chk("ill_flag",    64'(res_illegal), 64'd1);
        chk("ill_data",    res_data, 64'd0);
        chk("ill_div0",    64'(res_div0), 64'd0);
        for (int i = 0; i < 32; i++) begin
            read_reg(5'(i), v);
            chk("ill_reg_unchanged", v, exp_regs[i]);
        end
        retire();

        // SHFTLI r3, L=70: only the low 6 bits count, so 7 << 6
        issue(enc(5'b00111, 5'd3, 5'd0, 5'd0, 12'd70));
        wait_resp(10, lat, rdy_seen);
        chk("shftli_data",    res_data, 64'd448);
        chk("shftli_illegal", 64'(res_illegal), 64'd0);
        exp_regs[3] = 64'd448;
        retire();

        // Reset at iteration 30 of a DIV
        issue(enc(5'b11101, 5'd4, 5'd2, 5'd3, 12'h000));
        repeat (29) @(posedge clk);
        do_reset();
        chk("mrst_instr_ready", 64'(instr_ready), 64'd1);
        chk("mrst_res_valid",   64'(res_valid),   64'd0);
        chk("mrst_res_data",    res_data,         64'd0);
        chk("mrst_res_div0",    64'(res_div0),    64'd0);
        for (int i = 0; i < 32; i++) begin
            read_reg(5'(i), v);
            chk("mrst_reg", v, 64'd0);
        end
        repeat (40) @(posedge clk);
        #1;
        read_reg(5'd4, v);
        chk("mrst_no_late_write", v, 64'd0);
        chk("mrst_still_idle", 64'(res_valid), 64'd0);

        // Unit works normally after the abort
        issue(enc(5'b10010, 5'd1, 5'd0, 5'd0, 12'hFFF));
        wait_resp(10, lat, rdy_seen);
        chk("post_latency", 64'(lat), 64'd1);
        chk("post_data",    res_data, 64'hFFFF_FFFF_FFFF_FFFF);
        chk("post_rd",      64'(res_rd), 64'd1);
        retire();

        $display("[TB] %0d tests run, %0d failed", tests, fails);
        $finish;
    end

endmodule
